// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl - cache miss fill and clear-sweep write sequencer.
// Every output is a flop; next values are computed from the next state.
module cache_fill_ctrl #(
  parameter int ADDR_W = 11,
  parameter int TAG_W  = 14,
  parameter int DATA_W = 16,
  parameter int WR_CYC = 1
) (
  input  logic              sysclk,
  input  logic              sys_rst,
  input  logic              miss_req,
  input  logic [ADDR_W-1:0] miss_ca,
  input  logic [TAG_W-1:0]  miss_cpn,
  input  logic              wcinh_n,
  input  logic              cclr_req,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_err,
  output logic [ADDR_W-1:0] ca_out,
  output logic [DATA_W-1:0] cd_out,
  output logic [TAG_W-1:0]  cpn_out,
  output logic              ubit_out,
  output logic              wca_n,
  output logic [DATA_W-1:0] fwd_data,
  output logic              fwd_valid,
  output logic              fill_done,
  output logic              fill_err,
  output logic              clr_done,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, REQ, WRITE, DONE, CLEAR} state_t;

  localparam logic [1:0] WR_LAST = 2'(WR_CYC - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [1:0]        wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] cap_ca_q, cap_ca_d;
  logic [TAG_W-1:0]  cap_cpn_q, cap_cpn_d;
  logic              cap_wcinh_n_q, cap_wcinh_n_d;

  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] ca_q, ca_d;
  logic [DATA_W-1:0] cd_q, cd_d;
  logic [TAG_W-1:0]  cpn_q, cpn_d;
  logic              ubit_q, ubit_d;
  logic              wca_n_q, wca_n_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
  logic              fwd_valid_q, fwd_valid_d;
  logic              fill_done_q, fill_done_d;
  logic              fill_err_q, fill_err_d;
  logic              clr_done_q, clr_done_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    wr_cnt_d      = wr_cnt_q;
    cap_ca_d      = cap_ca_q;
    cap_cpn_d     = cap_cpn_q;
    cap_wcinh_n_d = cap_wcinh_n_q;
    mem_req_d     = 1'b0;
    ca_d          = ca_q;
    cd_d          = cd_q;
    cpn_d         = cpn_q;
    ubit_d        = ubit_q;
    wca_n_d       = 1'b1;
    fwd_data_d    = fwd_data_q;
    fwd_valid_d   = 1'b0;
    fill_done_d   = 1'b0;
    fill_err_d    = 1'b0;
    clr_done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // A clear outranks a miss; the level-held miss is picked up later.
        if (cclr_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
          wca_n_d   = 1'b0;
          ca_d      = '0;
          cd_d      = '0;
          cpn_d     = '0;
          ubit_d    = 1'b0;
        end else if (miss_req) begin
          state_d       = REQ;
          cap_ca_d      = miss_ca;
          cap_cpn_d     = miss_cpn;
          cap_wcinh_n_d = wcinh_n;
          mem_req_d     = 1'b1;
        end
      end
      REQ: begin
        if (mem_ack) begin
          if (mem_err) begin
            state_d    = DONE;
            fill_err_d = 1'b1;
          end else begin
            state_d     = WRITE;
            wr_cnt_d    = '0;
            wca_n_d     = ~cap_wcinh_n_q;
            ca_d        = cap_ca_q;
            cd_d        = mem_data;
            cpn_d       = cap_cpn_q;
            ubit_d      = 1'b1;
            fwd_data_d  = mem_data;
            fwd_valid_d = 1'b1;
          end
        end else begin
          mem_req_d = 1'b1;
        end
      end
      WRITE: begin
        if (wr_cnt_q == WR_LAST) begin
          state_d     = DONE;
          fill_done_d = 1'b1;
        end else begin
          wr_cnt_d = wr_cnt_q + 2'd1;
          wca_n_d  = ~cap_wcinh_n_q;
        end
      end
      DONE: state_d = IDLE;
      CLEAR: begin
        // Counter holds the index on the bus now; stop after the top index.
        if (clr_cnt_q == {ADDR_W{1'b1}}) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
          ca_d      = clr_cnt_q + 1'b1;
          wca_n_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      clr_cnt_q     <= '0;
      wr_cnt_q      <= '0;
      cap_ca_q      <= '0;
      cap_cpn_q     <= '0;
      cap_wcinh_n_q <= 1'b1;
      mem_req_q     <= 1'b0;
      ca_q          <= '0;
      cd_q          <= '0;
      cpn_q         <= '0;
      ubit_q        <= 1'b0;
      wca_n_q       <= 1'b1;
      fwd_data_q    <= '0;
      fwd_valid_q   <= 1'b0;
      fill_done_q   <= 1'b0;
      fill_err_q    <= 1'b0;
      clr_done_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      cap_ca_q      <= cap_ca_d;
      cap_cpn_q     <= cap_cpn_d;
      cap_wcinh_n_q <= cap_wcinh_n_d;
      mem_req_q     <= mem_req_d;
      ca_q          <= ca_d;
      cd_q          <= cd_d;
      cpn_q         <= cpn_d;
      ubit_q        <= ubit_d;
      wca_n_q       <= wca_n_d;
      fwd_data_q    <= fwd_data_d;
      fwd_valid_q   <= fwd_valid_d;
      fill_done_q   <= fill_done_d;
      fill_err_q    <= fill_err_d;
      clr_done_q    <= clr_done_d;
      busy_q        <= busy_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign ca_out    = ca_q;
  assign cd_out    = cd_q;
  assign cpn_out   = cpn_q;
  assign ubit_out  = ubit_q;
  assign wca_n     = wca_n_q;
  assign fwd_data  = fwd_data_q;
  assign fwd_valid = fwd_valid_q;
  assign fill_done = fill_done_q;
  assign fill_err  = fill_err_q;
  assign clr_done  = clr_done_q;
  assign busy      = busy_q;

endmodule
